// File: rtl/relay_framer_pkg.sv
// Shared mode codes, default SOF/EOF patterns and helpers for the relay framer.
// No logic here: constants and a pure decode function only.
// No flow control: nothing in this file holds state.
package relay_framer_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_SNIFFER  = 3'b000;
  localparam mode_t TAGSIM_LISTEN = 3'b001;
  localparam mode_t TAGSIM_MOD    = 3'b010;
  localparam mode_t READER_LISTEN = 3'b011;
  localparam mode_t READER_MOD    = 3'b100;
  localparam mode_t FAKE_READER   = 3'b101;
  localparam mode_t FAKE_TAG      = 3'b110;

  localparam logic [19:0] DEF_RD_SOF      = 20'h0000C;
  localparam logic [19:0] DEF_RD_EOF1     = 20'h00000;
  localparam logic [19:0] DEF_RD_EOF2     = 20'hC0000;
  localparam logic [19:0] DEF_TG_SOF      = 20'h000F0;
  localparam logic [19:0] DEF_TG_EOF      = 20'h00000;
  localparam logic [19:0] DEF_TG_EOF_MASK = 20'h00FFF;

  // Only the two fake modes run the bit clock and the framer.
  function automatic logic is_fake(input mode_t m);
    return (m == FAKE_READER) || (m == FAKE_TAG);
  endfunction

endpackage

// File: rtl/relay_framer_if.sv
// Bundle of mode request, serial bit input and framer status outputs.
// Latency: none, wires only.
// No backpressure: all signals are level or single-cycle pulses.
interface relay_framer_if;
  import relay_framer_pkg::*;

  mode_t       hi_simulate_mod_type;
  logic        data_in;
  mode_t       mod_type;
  logic        data_out;
  logic        bit_strobe;
  logic        sof_pulse;
  logic        eof_pulse;
  logic        timeout_err;
  logic [15:0] frame_len;

  modport master (
    output hi_simulate_mod_type, data_in,
    input  mod_type, data_out, bit_strobe, sof_pulse, eof_pulse, timeout_err, frame_len
  );

  modport slave (
    input  hi_simulate_mod_type, data_in,
    output mod_type, data_out, bit_strobe, sof_pulse, eof_pulse, timeout_err, frame_len
  );

endinterface

// File: rtl/relay_framer_shift_detector.sv
// Receive shift buffer, bit-alignment counter and SOF/EOF pattern comparators.
// Latency: hits are combinational on the post-shift buffer of the current tick.
// No backpressure: one bit is consumed on every tick.
module relay_shift_detector #(
  parameter int               BUF_W       = 20,
  parameter int               ALIGN_W     = 3,
  parameter int               DATA_TAP    = 3,
  parameter logic [BUF_W-1:0] RD_SOF      = '0,
  parameter logic [BUF_W-1:0] RD_EOF1     = '0,
  parameter logic [BUF_W-1:0] RD_EOF2     = '0,
  parameter logic [BUF_W-1:0] TG_SOF      = '0,
  parameter logic [BUF_W-1:0] TG_EOF      = '0,
  parameter logic [BUF_W-1:0] TG_EOF_MASK = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  input  logic align_clr,
  input  logic reader_mode,
  input  logic data_in,
  output logic sof_hit,
  output logic eof_hit,
  output logic data_tap
);

  logic [BUF_W-1:0]   shreg_q;
  logic [BUF_W-1:0]   shreg_nxt;
  logic [ALIGN_W-1:0] align_q;
  logic [ALIGN_W-1:0] align_nxt;

  assign shreg_nxt = {shreg_q[BUF_W-2:0], data_in};
  assign align_nxt = align_q + 1'b1;
  assign data_tap  = shreg_q[DATA_TAP];

  // Compare against the buffer as it will look after this tick's shift.
  always_comb begin
    sof_hit = 1'b0;
    eof_hit = 1'b0;
    if (tick) begin
      if (reader_mode) begin
        sof_hit = (shreg_nxt == RD_SOF);
        eof_hit = (align_nxt == '0) && ((shreg_nxt == RD_EOF1) || (shreg_nxt == RD_EOF2));
      end else begin
        sof_hit = (shreg_nxt == TG_SOF);
        eof_hit = (align_nxt == '0) && ((shreg_nxt & TG_EOF_MASK) == TG_EOF);
      end
    end
  end

  // Shift one bit per tick; a clear wins over everything, SOF realigns the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      align_q <= '0;
    end else if (clr) begin
      shreg_q <= '0;
      align_q <= '0;
    end else if (tick) begin
      shreg_q <= shreg_nxt;
      align_q <= align_clr ? '0 : align_nxt;
    end
  end

endmodule

// File: rtl/relay_framer.sv
// Relay framer: bit-rate divider plus OFF/LISTEN/MOD framing FSM with timeout.
// Latency: mod_type and pulses update one clk after the deciding tick.
// No backpressure: the serial stream is sampled at the divider rate unconditionally.
module relay_framer
  import relay_framer_pkg::*;
#(
  parameter int               DIV_W       = 4,
  parameter logic [DIV_W-1:0] DIV_MATCH   = DIV_W'(8),
  parameter int               BUF_W       = 20,
  parameter int               ALIGN_W     = 3,
  parameter int               DATA_TAP    = 3,
  parameter logic [BUF_W-1:0] RD_SOF      = BUF_W'(DEF_RD_SOF),
  parameter logic [BUF_W-1:0] RD_EOF1     = BUF_W'(DEF_RD_EOF1),
  parameter logic [BUF_W-1:0] RD_EOF2     = BUF_W'(DEF_RD_EOF2),
  parameter logic [BUF_W-1:0] TG_SOF      = BUF_W'(DEF_TG_SOF),
  parameter logic [BUF_W-1:0] TG_EOF      = BUF_W'(DEF_TG_EOF),
  parameter logic [BUF_W-1:0] TG_EOF_MASK = BUF_W'(DEF_TG_EOF_MASK),
  parameter int               MAX_FRAME   = 1024
) (
  input  logic           clk,
  input  logic           reset,
  relay_framer_if.slave  bus
);

  localparam logic [1:0]  ST_OFF    = 2'd0;
  localparam logic [1:0]  ST_LISTEN = 2'd1;
  localparam logic [1:0]  ST_MOD    = 2'd2;
  localparam logic [15:0] TMO_CNT   = 16'(MAX_FRAME - 1);

  logic [1:0]       state_q, state_d;
  mode_t            mode_q, mod_type_d;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      frame_cnt_q;
  logic             fake, tick, reader, mode_chg, det_clr;
  logic             sof_hit, eof_hit, sof_take, eof_take, tmo_take;

  assign fake     = is_fake(bus.hi_simulate_mod_type);
  assign tick     = fake && (div_q == DIV_MATCH);
  assign reader   = (bus.hi_simulate_mod_type == FAKE_READER);
  // Entering a fake mode from OFF or hopping between fake modes restarts framing.
  assign mode_chg = fake && ((state_q == ST_OFF) || (bus.hi_simulate_mod_type != mode_q));
  assign det_clr  = !fake || mode_chg;
  assign sof_take = !det_clr && (state_q == ST_LISTEN) && sof_hit;
  assign eof_take = !det_clr && (state_q == ST_MOD) && eof_hit;
  // EOF on the same tick as the limit takes priority over the timeout.
  assign tmo_take = !det_clr && (state_q == ST_MOD) && tick && !eof_hit &&
                    (frame_cnt_q >= TMO_CNT);

  relay_shift_detector #(
    .BUF_W(BUF_W), .ALIGN_W(ALIGN_W), .DATA_TAP(DATA_TAP),
    .RD_SOF(RD_SOF), .RD_EOF1(RD_EOF1), .RD_EOF2(RD_EOF2),
    .TG_SOF(TG_SOF), .TG_EOF(TG_EOF), .TG_EOF_MASK(TG_EOF_MASK)
  ) u_det (
    .clk(clk), .reset(reset), .clr(det_clr), .tick(tick), .align_clr(sof_take),
    .reader_mode(reader), .data_in(bus.data_in),
    .sof_hit(sof_hit), .eof_hit(eof_hit), .data_tap(bus.data_out)
  );

  // Next framing state and the modulation command it implies.
  always_comb begin
    state_d = state_q;
    if (!fake)                     state_d = ST_OFF;
    else if (mode_chg)             state_d = ST_LISTEN;
    else if (sof_take)             state_d = ST_MOD;
    else if (eof_take || tmo_take) state_d = ST_LISTEN;

    mod_type_d = bus.hi_simulate_mod_type;
    if (state_d == ST_LISTEN)   mod_type_d = reader ? READER_LISTEN : TAGSIM_LISTEN;
    else if (state_d == ST_MOD) mod_type_d = reader ? READER_MOD : TAGSIM_MOD;
  end

  // Free-running divider, FSM state and the tick counter of the current frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      state_q     <= ST_OFF;
      mode_q      <= MODE_SNIFFER;
      frame_cnt_q <= '0;
    end else begin
      div_q   <= div_q + 1'b1;
      state_q <= state_d;
      if (fake) mode_q <= bus.hi_simulate_mod_type;
      if (det_clr || sof_take)
        frame_cnt_q <= '0;
      else if ((state_q == ST_MOD) && tick && (frame_cnt_q != 16'hFFFF))
        frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Registered outputs: command, strobes and the length of the last good frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mod_type    <= MODE_SNIFFER;
      bus.bit_strobe  <= 1'b0;
      bus.sof_pulse   <= 1'b0;
      bus.eof_pulse   <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.frame_len   <= '0;
    end else begin
      bus.mod_type    <= mod_type_d;
      bus.bit_strobe  <= tick;
      bus.sof_pulse   <= sof_take;
      bus.eof_pulse   <= eof_take;
      bus.timeout_err <= tmo_take;
      if (eof_take)
        bus.frame_len <= (frame_cnt_q == 16'hFFFF) ? 16'hFFFF : frame_cnt_q + 16'd1;
    end
  end

endmodule
